// File: rtl/lcd_pkg.sv
// Shared constants and the DDRAM address-step rule for the HD44780-style bus decoder.
package lcd_pkg;

  localparam logic [7:0] BLANK      = 8'h20;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_END  = 7'h67;

  // Commands are decoded by their highest set bit; each mask is that bit.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  typedef enum logic [1:0] {StByte8, StNibHi, StNibLo} nib_state_e;

  // Wraps between the two 40-entry line windows; out-of-window addresses step plainly.
  function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
    if (inc) begin
      if (addr == LINE1_END)      return LINE2_BASE;
      else if (addr == LINE2_END) return 7'h00;
      else                        return addr + 7'd1;
    end else begin
      if (addr == 7'h00)           return LINE2_END;
      else if (addr == LINE2_BASE) return LINE1_END;
      else                         return addr - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// LCD parallel bus as driven by the initialise driver (master) and observed by the decoder.
interface lcd_bus_decoder_if;
  logic       lcd_rs;
  logic       lcd_w;
  logic       lcd_e;
  logic [3:0] data;

  modport master (output lcd_rs, output lcd_w, output lcd_e, output data);
  modport slave  (input lcd_rs, input lcd_w, input lcd_e, input data);
endinterface

// File: rtl/lcd_nibble_assembler.sv
// Detects enable falling edges and assembles strobes into executable bytes (8- or 4-bit mode).
module lcd_nibble_assembler
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lcd_bus_decoder_if.slave   bus,
  output logic               four_bit,
  output logic               exec_valid,
  output logic               exec_rs,
  output logic [7:0]         exec_byte
);

  logic       e_q;
  logic       strobe;
  logic       func_set;
  logic [3:0] hi_q;
  nib_state_e state_q;

  // Read strobes never advance the machine.
  assign strobe = e_q & ~bus.lcd_e & ~bus.lcd_w;

  // Combinational so the byte executes on the very edge that sees the fall.
  always_comb begin
    exec_valid = 1'b0;
    exec_rs    = bus.lcd_rs;
    exec_byte  = {bus.data, 4'h0};
    if (strobe) begin
      case (state_q)
        StByte8: exec_valid = 1'b1;
        StNibLo: begin
          exec_valid = 1'b1;
          exec_byte  = {hi_q, bus.data};
        end
        default: ;
      endcase
    end
  end

  assign func_set = exec_valid & ~exec_rs & (exec_byte[7:5] == 3'b001);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= 1'b0;
      hi_q     <= 4'h0;
      state_q  <= StByte8;
      four_bit <= 1'b0;
    end else begin
      e_q <= bus.lcd_e;
      if (strobe) begin
        case (state_q)
          StByte8: begin
            if (func_set && !exec_byte[4]) begin
              state_q  <= StNibHi;
              four_bit <= 1'b1;
            end
          end
          StNibHi: begin
            hi_q    <= bus.data;
            state_q <= StNibLo;
          end
          StNibLo: begin
            if (func_set && exec_byte[4]) begin
              state_q  <= StByte8;
              four_bit <= 1'b0;
            end else begin
              state_q <= StNibHi;
            end
          end
          default: state_q <= StByte8;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Receive-side LCD model: executes the driver's command subset and rebuilds both display lines.
module lcd_bus_decoder
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lcd_bus_decoder_if.slave   bus,
  output logic [127:0]       string1,
  output logic [127:0]       string2,
  output logic [6:0]         cursor_addr,
  output logic               four_bit,
  output logic               display_on,
  output logic               byte_valid,
  output logic               byte_rs,
  output logic [7:0]         byte_out
);

  logic       exec_valid;
  logic       exec_rs;
  logic [7:0] exec_byte;
  logic       inc_q;
  logic       ddram_sel_q;
  logic [6:0] col_lsb;

  lcd_nibble_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .four_bit   (four_bit),
    .exec_valid (exec_valid),
    .exec_rs    (exec_rs),
    .exec_byte  (exec_byte)
  );

  // Column 0 sits in the top byte, so the slice base is (15 - col) * 8.
  assign col_lsb = {~cursor_addr[3:0], 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      string1     <= {16{BLANK}};
      string2     <= {16{BLANK}};
      cursor_addr <= 7'h00;
      display_on  <= 1'b0;
      byte_valid  <= 1'b0;
      byte_rs     <= 1'b0;
      byte_out    <= 8'h00;
      inc_q       <= 1'b1;
      ddram_sel_q <= 1'b1;
    end else begin
      byte_valid <= exec_valid;
      if (exec_valid) begin
        byte_rs  <= exec_rs;
        byte_out <= exec_byte;
        if (exec_rs) begin
          if (ddram_sel_q && cursor_addr[6:4] == 3'b000) begin
            string1[col_lsb +: 8] <= exec_byte;
          end else if (ddram_sel_q && cursor_addr[6:4] == LINE2_BASE[6:4]) begin
            string2[col_lsb +: 8] <= exec_byte;
          end
          cursor_addr <= addr_step(cursor_addr, inc_q);
        end else if (exec_byte >= CMD_DDRAM) begin
          cursor_addr <= exec_byte[6:0];
          ddram_sel_q <= 1'b1;
        end else if (exec_byte >= CMD_CGRAM) begin
          ddram_sel_q <= 1'b0;
        end else if (exec_byte >= CMD_FUNC) begin
          // Data-length switching lives in the assembler.
        end else if (exec_byte >= CMD_SHIFT) begin
          if (!exec_byte[3]) cursor_addr <= addr_step(cursor_addr, exec_byte[2]);
        end else if (exec_byte >= CMD_DISP) begin
          display_on <= exec_byte[2];
        end else if (exec_byte >= CMD_ENTRY) begin
          inc_q <= exec_byte[1];
        end else if (exec_byte >= CMD_HOME) begin
          cursor_addr <= 7'h00;
          ddram_sel_q <= 1'b1;
        end else if (exec_byte == CMD_CLEAR) begin
          string1     <= {16{BLANK}};
          string2     <= {16{BLANK}};
          cursor_addr <= 7'h00;
          inc_q       <= 1'b1;
          ddram_sel_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Self-checking bench: a character-array display model checked every cycle, plus pinned literals.
module tb_lcd_bus_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] string1, string2;
  logic [6:0]   cursor_addr;
  logic         four_bit, display_on, byte_valid, byte_rs;
  logic [7:0]   byte_out;

  always #5 clk = ~clk;

  lcd_bus_decoder_if bus ();

  lcd_bus_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .string1     (string1),
    .string2     (string2),
    .cursor_addr (cursor_addr),
    .four_bit    (four_bit),
    .display_on  (display_on),
    .byte_valid  (byte_valid),
    .byte_rs     (byte_rs),
    .byte_out    (byte_out)
  );

  // Display model: two rows of characters and an integer address.
  logic [7:0] m_line [2][16];
  int         m_cur;
  bit         m_inc, m_dd, m_four, m_have_hi, m_disp;
  logic [3:0] m_hi;
  bit         exp_valid;
  logic       exp_rs;
  logic [7:0] exp_byte;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         chk_en   = 1'b0;
  logic [7:0] blog [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int step(input int a, input bit inc);
    if (inc) return (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
    else     return (a == 0) ? 103 : (a == 64) ? 39 : (a + 127) % 128;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) m_line[r][c] = 8'h20;
    m_cur = 0; m_inc = 1; m_dd = 1; m_four = 0; m_have_hi = 0; m_disp = 0;
    exp_valid = 0; exp_rs = 0; exp_byte = 8'h00;
  endtask

  task automatic model_exec(input bit rs, input logic [7:0] b);
    exp_valid = 1; exp_rs = rs; exp_byte = b;
    if (rs) begin
      if (m_dd && m_cur < 16) m_line[0][m_cur] = b;
      else if (m_dd && m_cur >= 64 && m_cur < 80) m_line[1][m_cur - 64] = b;
      m_cur = step(m_cur, m_inc);
    end else if (b >= 128) begin
      m_cur = b - 128; m_dd = 1;
    end else if (b >= 64) begin
      m_dd = 0;
    end else if (b >= 32) begin
      m_four = (b[4] == 1'b0);
    end else if (b >= 16) begin
      if (!b[3]) m_cur = step(m_cur, b[2]);
    end else if (b >= 8) begin
      m_disp = b[2];
    end else if (b >= 4) begin
      m_inc = b[1];
    end else if (b >= 2) begin
      m_cur = 0; m_dd = 1;
    end else if (b == 1) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 16; c++) m_line[r][c] = 8'h20;
      m_cur = 0; m_inc = 1; m_dd = 1;
    end
  endtask

  task automatic model_strobe(input bit rs, input bit w, input logic [3:0] nib);
    if (w) return;
    if (!m_four) model_exec(rs, {nib, 4'h0});
    else if (!m_have_hi) begin
      m_hi = nib; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      model_exec(rs, {m_hi, nib});
    end
  endtask

  task automatic strobe(input bit rs, input bit w, input logic [3:0] nib);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_w = w; bus.data = nib; bus.lcd_e = 1'b1;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    @(posedge clk);
    model_strobe(rs, w, nib);
    @(posedge clk);
    exp_valid = 0;
  endtask

  task automatic send4(input bit rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.lcd_e = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [127:0] e1, e2;
      for (int c = 0; c < 16; c++) begin
        e1[127 - 8 * c -: 8] = m_line[0][c];
        e2[127 - 8 * c -: 8] = m_line[1][c];
      end
      check("string1", string1, e1);
      check("string2", string2, e2);
      check("cursor_addr", 128'(cursor_addr), 128'(m_cur[6:0]));
      check("four_bit", 128'(four_bit), 128'(m_four));
      check("display_on", 128'(display_on), 128'(m_disp));
      check("byte_valid", 128'(byte_valid), 128'(exp_valid));
      check("byte_rs", 128'(byte_rs), 128'(exp_rs));
      check("byte_out", 128'(byte_out), 128'(exp_byte));
      if (byte_valid === 1'b1) blog.push_back(byte_out);
    end
  end

  initial begin
    reset = 1'b1;
    bus.lcd_rs = 1'b0; bus.lcd_w = 1'b0; bus.lcd_e = 1'b0; bus.data = 4'h0;
    do_reset();
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    check("lit_idle_no_pulse", 128'(blog.size()), 128'd0);
    check("lit_reset_string1", string1, {16{8'h20}});

    // Driver init: three 8-bit wake-ups, switch to 4-bit, then function set 0x28.
    strobe(0, 0, 4'h3); strobe(0, 0, 4'h3); strobe(0, 0, 4'h3); strobe(0, 0, 4'h2);
    @(negedge clk);
    check("lit_four_bit_set", 128'(four_bit), 128'd1);
    send4(0, 8'h28);
    @(negedge clk);
    check("lit_init_count", 128'(blog.size()), 128'd5);
    check("lit_init_bytes", 128'({blog[0], blog[1], blog[2], blog[3], blog[4]}),
          128'(40'h30_30_30_20_28));

    send4(0, 8'h0C); send4(0, 8'h80); send4(1, 8'h48); send4(1, 8'h69);
    @(negedge clk);
    check("lit_hi_text", 128'(string1[127:112]), 128'(16'h4869));
    check("lit_hi_cursor", 128'(cursor_addr), 128'(7'h02));
    check("lit_display_on", 128'(display_on), 128'd1);

    send4(0, 8'hC0); send4(1, 8'h41);
    @(negedge clk);
    check("lit_line2_char", 128'(string2[127:120]), 128'(8'h41));
    check("lit_line2_cursor", 128'(cursor_addr), 128'(7'h41));

    send4(0, 8'hA7); send4(1, 8'h58);
    @(negedge clk);
    check("lit_wrap_cursor", 128'(cursor_addr), 128'(7'h40));
    check("lit_wrap_string1", string1, {16'h4869, {14{8'h20}}});
    check("lit_wrap_string2", string2, {8'h41, {15{8'h20}}});

    send4(0, 8'h04); send4(0, 8'h80); send4(1, 8'h5A);
    @(negedge clk);
    check("lit_dec_cursor", 128'(cursor_addr), 128'(7'h67));
    check("lit_dec_char", 128'(string1[127:120]), 128'(8'h5A));

    // Read strobe between the two nibbles of 0x42.
    send4(0, 8'h06); send4(0, 8'h85);
    strobe(1, 0, 4'h4); strobe(1, 1, 4'hF); strobe(1, 0, 4'h2);
    @(negedge clk);
    check("lit_rd_char", 128'(string1[87:80]), 128'(8'h42));
    check("lit_rd_cursor", 128'(cursor_addr), 128'(7'h06));

    send4(0, 8'h10);
    @(negedge clk);
    check("lit_shift_left", 128'(cursor_addr), 128'(7'h05));
    send4(0, 8'h14);
    @(negedge clk);
    check("lit_shift_right", 128'(cursor_addr), 128'(7'h06));

    send4(0, 8'h01);
    @(negedge clk);
    check("lit_clear_s1", string1, {16{8'h20}});
    check("lit_clear_s2", string2, {16{8'h20}});
    check("lit_clear_cursor", 128'(cursor_addr), 128'd0);

    // Reset after a lone high nibble: following strobes are whole 8-bit bytes.
    strobe(0, 0, 4'h8);
    do_reset();
    strobe(0, 0, 4'h8); strobe(0, 0, 4'h1);
    @(negedge clk);
    check("lit_rst_four_bit", 128'(four_bit), 128'd0);
    check("lit_rst_cursor", 128'(cursor_addr), 128'(7'h67));
    check("lit_rst_bytes", 128'({blog[blog.size() - 2], blog[blog.size() - 1]}),
          128'(16'h8010));

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
